serializer: RTL and testbench
=============================

SERIALIZER -- requirements
Module: serializer

Interface
REQ-001 SHALL have parameter WORD_W, default 8, width of parallel word.
REQ-002 SHALL have parameter HI_CYCLES, default 1, clocks write_out is high per bit (range 1..255).
REQ-003 SHALL have parameter LO_CYCLES, default 1, clocks write_out is low after each bit (range 1..255).
REQ-004 SHALL have port clock  input  1  sole clock, rising edge.
REQ-005 SHALL have port reset  input  1  reset, synchronous and active-high.
REQ-006 SHALL have port in_data  input  WORD_W  parallel word to transmit.
REQ-007 SHALL have port in_valid  input  1  in_data valid.
REQ-008 SHALL have port in_ready  output  1  block can accept a word.
REQ-009 SHALL have port status_in  input  1  receiver ready for a new word (deserializer status_out).
REQ-010 SHALL have port data_out  output  1  serial bit (to deserializer data_in).
REQ-011 SHALL have port write_out  output  1  bit strobe (to deserializer write_in).
REQ-012 SHALL have port busy_out  output  1  word captured and not yet fully sent.
REQ-013 SHALL have port done_out  output  1  one-clock pulse at word completion.

Function
REQ-014 SHALL implement FSM states IDLE, WAIT_RDY, SEND_HI, SEND_LO.
REQ-015 SHALL drive in_ready=1 only in IDLE; a word is captured at an edge where in_ready and in_valid are both 1.
REQ-016 SHALL, on capture, load the shift register with in_data and move IDLE->WAIT_RDY; in_valid without in_ready is ignored.
REQ-017 SHALL, in WAIT_RDY, wait indefinitely until status_in=1 is sampled, then move to SEND_HI with bit index 0.
REQ-018 SHALL send MSB first: bit index k drives data_out = word[WORD_W-1-k].
REQ-019 SHALL keep data_out stable for the full HI_CYCLES+LO_CYCLES of each bit.
REQ-020 SHALL hold write_out=1 for exactly HI_CYCLES clocks in SEND_HI, then write_out=0 for exactly LO_CYCLES clocks in SEND_LO.
REQ-021 SHALL, after SEND_LO of a non-final bit, increment bit index and return to SEND_HI.
REQ-022 SHALL, after SEND_LO of bit WORD_W-1, go to IDLE and pulse done_out for one clock on that same transition.
REQ-023 SHALL take exactly WORD_W*(HI_CYCLES+LO_CYCLES) clocks from first write_out rise to done_out (16 at defaults).
REQ-024 SHALL ignore status_in outside WAIT_RDY; a started word always completes even if status_in drops.
REQ-025 SHALL assert busy_out in WAIT_RDY, SEND_HI, SEND_LO; deassert in IDLE.
REQ-026 SHALL drive data_out=0 in IDLE and WAIT_RDY.
REQ-027 SHALL use a phase counter sized for max(HI_CYCLES,LO_CYCLES) and a bit index of $clog2(WORD_W) bits, with no wrap beyond WORD_W-1.
REQ-028 SHALL register all outputs except in_ready, which is decoded from state.

Reset
REQ-029 SHALL, at a rising edge with reset=1, enter IDLE, clear shift register, bit index and phase counter.
REQ-030 SHALL hold reset outputs: in_ready=1 after reset released, data_out=0, write_out=0, busy_out=0, done_out=0.
REQ-031 SHALL abort a word in progress on reset with no done_out pulse; the aborted word is lost.

Structure
REQ-032 SHALL place the state enum and default WORD_W in a shared package serializer_pkg.
REQ-033 SHALL use one sub-module, serializer_bit_timer, counting HI/LO phases and signalling phase end.

Verification
REQ-034 Reset mid-word: assert reset at bit 3 of 0xA5 -> next clock write_out=0, busy_out=0, no done_out, in_ready=1 after release.
REQ-035 Single word 0x80, status_in=1, defaults -> write_out pulses 8 times, data_out 1 then seven 0, done_out exactly 16 clocks after first write_out rise.
REQ-036 Status gating: capture 0x3C with status_in=0 for 20 clocks -> no write_out, busy_out=1; raise status_in -> 0,0,1,1,1,1,0,0 sent.
REQ-037 Status drop mid-word: 0xFF, drop status_in after bit 2 -> all 8 strobes still emitted, done_out pulses.
REQ-038 Back-to-back: in_valid held with 0x81 then 0x82 -> second captured only in IDLE after done_out, no overlap of strobes.
REQ-039 Timing params HI_CYCLES=10, LO_CYCLES=10, word 0x01 -> each strobe 10 clocks high, 10 low, 160 clocks total, data_out=1 only on bit 7.

Source files
------------

// File: rtl/serializer_pkg.sv
// Shared types and sizing helpers for the serializer block.
package serializer_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_RDY = 2'd1,
    SEND_HI  = 2'd2,
    SEND_LO  = 2'd3
  } state_e;

  localparam int DEFAULT_WORD_W = 8;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Bits needed to hold values 0..n-1, never less than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/serializer_bit_timer.sv
// Phase timer: loads a phase length minus one and counts down to zero.
// phase_end is high during the last clock of the current phase.
module serializer_bit_timer #(
  parameter int CNT_W = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             phase_end
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Load a new phase length, otherwise count down and park at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  // Counter register with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign phase_end = (cnt_q == '0);

endmodule

// File: rtl/serializer.sv
// Parallel-to-serial transmitter with receiver-ready gating and strobed bits.
//
//   state    | meaning
//   ---------+------------------------------------------------------------
//   IDLE     | accepting a word (in_ready=1), serial outputs quiet
//   WAIT_RDY | word captured, waiting for status_in from the receiver
//   SEND_HI  | current bit on data_out, write_out high for HI_CYCLES
//   SEND_LO  | current bit held on data_out, write_out low for LO_CYCLES
module serializer
  import serializer_pkg::*;
#(
  parameter int WORD_W    = DEFAULT_WORD_W,
  parameter int HI_CYCLES = 1,
  parameter int LO_CYCLES = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [WORD_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              status_in,
  output logic              data_out,
  output logic              write_out,
  output logic              busy_out,
  output logic              done_out
);

  localparam int CNT_W = cnt_width(max2(HI_CYCLES, LO_CYCLES));
  localparam int IDX_W = cnt_width(WORD_W);
  localparam logic [CNT_W-1:0] HI_LOAD  = CNT_W'(HI_CYCLES - 1);
  localparam logic [CNT_W-1:0] LO_LOAD  = CNT_W'(LO_CYCLES - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORD_W - 1);

  state_e            state_q, state_d;
  logic [WORD_W-1:0] shift_q, shift_d;
  logic [IDX_W-1:0]  bit_idx_q, bit_idx_d;
  logic              data_out_q, data_out_d;
  logic              write_out_q, write_out_d;
  logic              busy_out_q, busy_out_d;
  logic              done_out_q, done_out_d;

  logic              tmr_load;
  logic [CNT_W-1:0]  tmr_load_val;
  logic              phase_end;

  serializer_bit_timer #(
    .CNT_W(CNT_W)
  ) u_bit_timer (
    .clock    (clock),
    .reset    (reset),
    .load     (tmr_load),
    .load_val (tmr_load_val),
    .phase_end(phase_end)
  );

  // Next-state logic; outputs are derived from the next state so they
  // appear registered in the same clock the state itself changes.
  always_comb begin
    state_d      = state_q;
    shift_d      = shift_q;
    bit_idx_d    = bit_idx_q;
    done_out_d   = 1'b0;
    tmr_load     = 1'b0;
    tmr_load_val = HI_LOAD;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          shift_d = in_data;
          state_d = WAIT_RDY;
        end
      end
      WAIT_RDY: begin
        if (status_in) begin
          state_d      = SEND_HI;
          bit_idx_d    = '0;
          tmr_load     = 1'b1;
          tmr_load_val = HI_LOAD;
        end
      end
      SEND_HI: begin
        if (phase_end) begin
          state_d      = SEND_LO;
          tmr_load     = 1'b1;
          tmr_load_val = LO_LOAD;
        end
      end
      SEND_LO: begin
        if (phase_end) begin
          if (bit_idx_q == LAST_IDX) begin
            state_d    = IDLE;
            done_out_d = 1'b1;
          end else begin
            // MSB always sits at the top of the shift register.
            bit_idx_d    = bit_idx_q + IDX_W'(1);
            shift_d      = shift_q << 1;
            state_d      = SEND_HI;
            tmr_load     = 1'b1;
            tmr_load_val = HI_LOAD;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    write_out_d = (state_d == SEND_HI);
    busy_out_d  = (state_d != IDLE);
    data_out_d  = ((state_d == SEND_HI) || (state_d == SEND_LO)) ? shift_d[WORD_W-1] : 1'b0;
  end

  // State, datapath and output registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      shift_q     <= '0;
      bit_idx_q   <= '0;
      data_out_q  <= 1'b0;
      write_out_q <= 1'b0;
      busy_out_q  <= 1'b0;
      done_out_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      bit_idx_q   <= bit_idx_d;
      data_out_q  <= data_out_d;
      write_out_q <= write_out_d;
      busy_out_q  <= busy_out_d;
      done_out_q  <= done_out_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign data_out  = data_out_q;
  assign write_out = write_out_q;
  assign busy_out  = busy_out_q;
  assign done_out  = done_out_q;

endmodule

// File: tb/tb_serializer.sv
// Self-checking bench for serializer: a strobe monitor rebuilds each word from
// the serial pins and is compared against table vectors and random words.
module tb_serializer;

  localparam int W   = 8;
  localparam int HI0 = 1;
  localparam int LO0 = 1;
  localparam int HI1 = 10;
  localparam int LO1 = 10;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  logic [W-1:0] in_data;
  logic         in_valid, in_ready, status_in, data_out, write_out, busy_out, done_out;
  logic [W-1:0] in_data1;
  logic         in_valid1, in_ready1, status1, data_out1, write_out1, busy_out1, done_out1;

  serializer #(.WORD_W(W), .HI_CYCLES(HI0), .LO_CYCLES(LO0)) dut0 (
    .clock(clock), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .status_in(status_in), .data_out(data_out),
    .write_out(write_out), .busy_out(busy_out), .done_out(done_out)
  );

  serializer #(.WORD_W(W), .HI_CYCLES(HI1), .LO_CYCLES(LO1)) dut1 (
    .clock(clock), .reset(reset), .in_data(in_data1), .in_valid(in_valid1),
    .in_ready(in_ready1), .status_in(status1), .data_out(data_out1),
    .write_out(write_out1), .busy_out(busy_out1), .done_out(done_out1)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name, input int waited);
    n_tests++;
    n_fail++;
    $display("FAIL %s: timed out after %0d cycles", name, waited);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Strobe monitor for dut0: samples on the falling edge.
  int           cyc         = 0;
  int           mon_err     = 0;
  int           got_done    = 0;
  int           mon_strobes = 0;
  int           mon_hi      = 0;
  int           mon_lo      = 0;
  int           mon_first   = 0;
  logic         mon_prev_wr = 1'b0;
  logic         mon_in_word = 1'b0;
  logic         mon_cur     = 1'b0;
  logic [W-1:0] mon_bits    = '0;
  logic [W-1:0] got_words[$];
  int           got_strb[$];
  int           got_lat[$];

  always @(negedge clock) begin
    cyc++;
    if (reset) begin
      mon_in_word = 1'b0;
      mon_strobes = 0;
      mon_prev_wr = 1'b0;
      mon_hi      = 0;
      mon_lo      = 0;
      mon_bits    = '0;
    end else begin
      if (busy_out && in_ready) mon_err++;
      if (mon_in_word && !done_out && !busy_out) mon_err++;
      if (done_out) begin
        if (write_out || busy_out || !in_ready || mon_lo != LO0) mon_err++;
        got_words.push_back(mon_bits);
        got_strb.push_back(mon_strobes);
        got_lat.push_back(cyc - mon_first);
        got_done++;
        mon_in_word = 1'b0;
        mon_strobes = 0;
        mon_bits    = '0;
        mon_hi      = 0;
        mon_lo      = 0;
      end else if (write_out) begin
        if (!mon_prev_wr) begin
          if (mon_strobes > 0 && mon_lo != LO0) mon_err++;
          if (mon_strobes == 0) mon_first = cyc;
          mon_cur     = data_out;
          mon_bits    = {mon_bits[W-2:0], data_out};
          mon_strobes++;
          mon_hi      = 1;
          mon_lo      = 0;
          mon_in_word = 1'b1;
        end else begin
          mon_hi++;
          if (data_out !== mon_cur) mon_err++;
        end
      end else begin
        if (mon_prev_wr && mon_hi != HI0) mon_err++;
        if (mon_in_word) begin
          mon_lo++;
          if (data_out !== mon_cur) mon_err++;
        end else if (data_out !== 1'b0) begin
          mon_err++;
        end
      end
      mon_prev_wr = write_out;
    end
  end

  // Present one word to dut0 and wait for its completion.
  task automatic run_word(input logic [W-1:0] w, input int stall, input int drop_after,
                          input bit noise);
    int n0, cnt, stall_bad;
    n0        = got_done;
    in_data   = w;
    in_valid  = 1'b1;
    status_in = (stall == 0);
    tick();
    in_valid  = 1'b0;
    in_data   = '0;
    stall_bad = 0;
    for (int i = 0; i < stall; i++) begin
      if (write_out || !busy_out) stall_bad++;
      tick();
    end
    if (stall > 0) chk("stall_gating", stall_bad, 0);
    status_in = 1'b1;
    cnt = 0;
    while (got_done == n0 && cnt < 300) begin
      tick();
      cnt++;
      if (drop_after >= 0 && mon_strobes > drop_after) status_in = 1'b0;
      if (noise) begin
        if (mon_strobes > 0) status_in = 1'($urandom_range(0, 1));
        in_valid = (cnt == 4);
        in_data  = W'($urandom);
      end
    end
    in_valid  = 1'b0;
    status_in = 1'b0;
    if (got_done == n0) fail_now("word_done", cnt);
  endtask

  task automatic check_word(input string tag, input logic [W-1:0] exp_bits,
                            input int exp_strobes, input int exp_len);
    if (got_words.size() == 0) begin
      fail_now({tag, "_missing"}, 0);
    end else begin
      chk({tag, "_bits"},    int'(got_words.pop_front()), int'(exp_bits));
      chk({tag, "_strobes"}, got_strb.pop_front(), exp_strobes);
      chk({tag, "_latency"}, got_lat.pop_front(), exp_len);
    end
    chk({tag, "_protocol"}, mon_err, 0);
  endtask

  typedef struct {
    logic [W-1:0] word;
    int           stall;
    int           drop_after;
    logic [W-1:0] exp_bits;
    int           exp_strobes;
    int           exp_len;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int n0, cnt, bad_w, bad_d, bad_done, bad_busy;
    logic [W-1:0] rw;

    vecs[0] = '{8'h80, 0,  -1, 8'b1000_0000, 8, 16};
    vecs[1] = '{8'h3C, 20, -1, 8'b0011_1100, 8, 16};
    vecs[2] = '{8'hFF, 0,   2, 8'b1111_1111, 8, 16};
    vecs[3] = '{8'hA5, 3,  -1, 8'b1010_0101, 8, 16};
    vecs[4] = '{8'h01, 1,  -1, 8'b0000_0001, 8, 16};

    reset     = 1'b1;
    in_data   = '0;
    in_valid  = 1'b0;
    status_in = 1'b0;
    in_data1  = '0;
    in_valid1 = 1'b0;
    status1   = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;
    @(negedge clock);
    chk("rst_in_ready",  in_ready,  1);
    chk("rst_data_out",  data_out,  0);
    chk("rst_write_out", write_out, 0);
    chk("rst_busy_out",  busy_out,  0);
    chk("rst_done_out",  done_out,  0);
    chk("rst_in_ready1", in_ready1, 1);
    tick();

    // Table vectors on the default-timing instance.
    foreach (vecs[i]) begin
      run_word(vecs[i].word, vecs[i].stall, vecs[i].drop_after, 1'b0);
      check_word($sformatf("vec%0d", i), vecs[i].exp_bits, vecs[i].exp_strobes, vecs[i].exp_len);
      tick();
    end

    // Back-to-back: in_valid held across two words.
    n0        = got_done;
    in_data   = 8'h81;
    in_valid  = 1'b1;
    status_in = 1'b1;
    tick();
    in_data   = 8'h82;
    cnt = 0;
    while (got_done < n0 + 2 && cnt < 300) begin
      tick();
      cnt++;
      if (got_done >= n0 + 1 && busy_out) in_valid = 1'b0;
    end
    in_valid  = 1'b0;
    status_in = 1'b0;
    if (got_done < n0 + 2) fail_now("b2b_done", cnt);
    check_word("b2b_first",  8'h81, 8, 2 * W * 1 / 2 * (HI0 + LO0));
    check_word("b2b_second", 8'h82, 8, W * (HI0 + LO0));
    tick();

    // Random words with a noisy status_in and stray in_valid while busy.
    for (int k = 0; k < 20; k++) begin
      rw = W'($urandom);
      run_word(rw, $urandom_range(0, 6), -1, 1'b1);
      check_word($sformatf("rnd%0d", k), rw, W, W * (HI0 + LO0));
      tick();
    end

    // Reset in the middle of bit 3 of 0xA5.
    n0        = got_done;
    in_data   = 8'hA5;
    in_valid  = 1'b1;
    status_in = 1'b1;
    tick();
    in_valid  = 1'b0;
    cnt = 0;
    while (mon_strobes < 4 && cnt < 50) begin
      tick();
      cnt++;
    end
    if (mon_strobes < 4) fail_now("midrst_reach_bit3", cnt);
    reset = 1'b1;
    @(posedge clock);
    @(negedge clock);
    chk("midrst_write_out", write_out, 0);
    chk("midrst_busy_out",  busy_out,  0);
    chk("midrst_done_out",  done_out,  0);
    chk("midrst_data_out",  data_out,  0);
    tick();
    reset     = 1'b0;
    status_in = 1'b0;
    @(negedge clock);
    chk("midrst_in_ready", in_ready, 1);
    repeat (30) tick();
    chk("midrst_no_done", got_done - n0, 0);
    chk("midrst_no_word", got_words.size(), 0);
    run_word(8'h5A, 0, -1, 1'b0);
    check_word("post_rst", 8'h5A, 8, 16);
    tick();

    // Long-phase instance: 10 clocks high, 10 low per bit, word 0x01.
    in_data1  = 8'h01;
    in_valid1 = 1'b1;
    status1   = 1'b1;
    tick();
    in_valid1 = 1'b0;
    cnt = 0;
    while (!write_out1 && cnt < 20) begin
      tick();
      cnt++;
    end
    if (!write_out1) begin
      fail_now("slow_first_rise", cnt);
    end else begin
      bad_w = 0; bad_d = 0; bad_done = 0; bad_busy = 0;
      for (int i = 0; i < W * (HI1 + LO1); i++) begin
        if (write_out1 !== ((i % (HI1 + LO1)) < HI1)) bad_w++;
        if (data_out1 !== ((i / (HI1 + LO1)) == 7)) bad_d++;
        if (done_out1) bad_done++;
        if (!busy_out1) bad_busy++;
        tick();
      end
      chk("slow_write_shape", bad_w, 0);
      chk("slow_data_shape",  bad_d, 0);
      chk("slow_early_done",  bad_done, 0);
      chk("slow_busy",        bad_busy, 0);
      chk("slow_done_at_160", done_out1, 1);
      chk("slow_write_end",   write_out1, 0);
      chk("slow_busy_end",    busy_out1, 0);
      tick();
      chk("slow_done_pulse",  done_out1, 0);
    end

    chk("final_protocol", mon_err, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
